// File: rtl/vm_pkg.sv
// Shared types, default coin/price tables and helpers for the parametrised vending controller.
package vm_pkg;

   localparam int unsigned VAL_BITS = 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      PAYOUT = 1'b1
   } vm_state_e;

   // Index 0 is the least significant byte: coins {1000,500,200,100}, prices {900,700,500,300} won.
   localparam logic [4*VAL_BITS-1:0] DEF_COIN_VALUES = {8'd10, 8'd5, 8'd2, 8'd1};
   localparam logic [4*VAL_BITS-1:0] DEF_PRICES      = {8'd9,  8'd7, 8'd5, 8'd3};

   function automatic logic vm_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/vm_coin_select.sv
// Greedy change selector: index of the largest coin whose value does not exceed the credit.
module vm_coin_select
   import vm_pkg::*;
#(
   parameter int unsigned NUM_COINS = 4,
   parameter logic [NUM_COINS*VAL_BITS-1:0] COIN_VALUES = DEF_COIN_VALUES,
   parameter int unsigned CREDIT_W  = 5,
   parameter int unsigned IDX_W     = 2
) (
   input  logic [CREDIT_W-1:0] credit_i,
   output logic [IDX_W-1:0]    coin_idx_c
);

   localparam int unsigned CMP_W = (CREDIT_W > VAL_BITS) ? CREDIT_W : VAL_BITS;

   // Coins are ordered ascending, so the last qualifying index is the largest.
   always_comb begin
      coin_idx_c = '0;
      for (int unsigned j = 0; j < NUM_COINS; j++) begin
         if (CMP_W'(COIN_VALUES[j*VAL_BITS +: VAL_BITS]) <= CMP_W'(credit_i)) begin
            coin_idx_c = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: credit, vend and one-coin-per-handshake change payout.
// Optional per-item stock counters with restock/sold_out are enabled by defining VM_STOCK_EN.
module vending_machine_param
   import vm_pkg::*;
#(
   parameter int unsigned NUM_COINS  = 4,
   parameter logic [NUM_COINS*VAL_BITS-1:0] COIN_VALUES = DEF_COIN_VALUES,
   parameter int unsigned NUM_ITEMS  = 4,
   parameter logic [NUM_ITEMS*VAL_BITS-1:0] PRICES = DEF_PRICES,
   parameter int unsigned MAX_CREDIT = 20,
   parameter int unsigned CREDIT_W   = 5,
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_COINS-1:0]         coin_in,
   input  logic [NUM_ITEMS-1:0]         buy,
   input  logic                         refund,
   input  logic                         change_ready,
`ifdef VM_STOCK_EN
   input  logic                         restock,
   output logic [NUM_ITEMS-1:0]         sold_out,
`endif
   output logic [CREDIT_W-1:0]          credit,
   output logic [NUM_ITEMS-1:0]         buy_available,
   output logic                         coin_accept,
   output logic                         coin_reject,
   output logic                         vend_ok,
   output logic                         vend_fail,
   output logic [$clog2(NUM_ITEMS)-1:0] vend_item,
   output logic                         change_valid,
   output logic [$clog2(NUM_COINS)-1:0] change_coin,
   output logic                         busy
);

   localparam int unsigned COIN_IW = $clog2(NUM_COINS);
   localparam int unsigned ITEM_IW = $clog2(NUM_ITEMS);
   localparam int unsigned CMP_W   = (CREDIT_W > VAL_BITS) ? CREDIT_W : VAL_BITS;
   localparam int unsigned SUM_W   = CMP_W + 1;

   // Elaboration-time parameter sanity.
   if (COIN_VALUES[VAL_BITS-1:0] != 8'd1) begin : g_bad_coin0
      $error("COIN_VALUES[0] must be 1 so payout terminates");
   end
   if (MAX_CREDIT >= (32'd1 << CREDIT_W)) begin : g_bad_max
      $error("MAX_CREDIT does not fit CREDIT_W");
   end
   if (STOCK_INIT >= (32'd1 << STOCK_W)) begin : g_bad_stock
      $error("STOCK_INIT does not fit STOCK_W");
   end

   vm_state_e            state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic                 coin_accept_q, coin_accept_d;
   logic                 coin_reject_q, coin_reject_d;
   logic                 vend_ok_q, vend_ok_d;
   logic                 vend_fail_q, vend_fail_d;
   logic [ITEM_IW-1:0]   vend_item_q, vend_item_d;
   logic                 change_valid_q, change_valid_d;
   logic [COIN_IW-1:0]   change_coin_q, change_coin_d;
   logic                 busy_q, busy_d;
   logic [NUM_ITEMS-1:0] buy_avail_q, buy_avail_d;
`ifdef VM_STOCK_EN
   logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;
   logic [NUM_ITEMS-1:0]              sold_out_q, sold_out_d;
`endif

   logic [COIN_IW-1:0]  coin_idx, sel_idx;
   logic [ITEM_IW-1:0]  buy_idx;
   logic                coin_any, coin_oh, buy_any, buy_oh, stock_ok;
   logic [CMP_W-1:0]    credit_w, coin_val, price_w, cur_val;
   logic [SUM_W-1:0]    sum_w;
   logic [CREDIT_W-1:0] pay_rem, sel_credit;

   // Lowest set bit of each request vector; only meaningful when one-hot.
   always_comb begin
      coin_idx = '0;
      for (int j = NUM_COINS - 1; j >= 0; j--) begin
         if (coin_in[j]) coin_idx = COIN_IW'(j);
      end
      buy_idx = '0;
      for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
         if (buy[i]) buy_idx = ITEM_IW'(i);
      end
   end

   assign coin_any   = |coin_in;
   assign buy_any    = |buy;
   assign coin_oh    = vm_onehot(32'(coin_in));
   assign buy_oh     = vm_onehot(32'(buy));
   assign credit_w   = CMP_W'(credit_q);
   assign coin_val   = CMP_W'(COIN_VALUES[32'(coin_idx)*VAL_BITS +: VAL_BITS]);
   assign price_w    = CMP_W'(PRICES[32'(buy_idx)*VAL_BITS +: VAL_BITS]);
   assign cur_val    = CMP_W'(COIN_VALUES[32'(change_coin_q)*VAL_BITS +: VAL_BITS]);
   assign sum_w      = SUM_W'(credit_w) + SUM_W'(coin_val);
   assign pay_rem    = CREDIT_W'(credit_w - cur_val);
   // Selector looks at the credit that will remain after this cycle's handshake.
   assign sel_credit = (state_q == PAYOUT) ? pay_rem : credit_q;

`ifdef VM_STOCK_EN
   assign stock_ok = (stock_q[buy_idx] != '0);
`else
   assign stock_ok = 1'b1;
`endif

   vm_coin_select #(
      .NUM_COINS   (NUM_COINS),
      .COIN_VALUES (COIN_VALUES),
      .CREDIT_W    (CREDIT_W),
      .IDX_W       (COIN_IW)
   ) u_coin_select (
      .credit_i   (sel_credit),
      .coin_idx_c (sel_idx)
   );

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      change_valid_d = change_valid_q;
      change_coin_d  = change_coin_q;
      vend_item_d    = vend_item_q;
      coin_accept_d  = 1'b0;
      coin_reject_d  = 1'b0;
      vend_ok_d      = 1'b0;
      vend_fail_d    = 1'b0;
`ifdef VM_STOCK_EN
      stock_d        = stock_q;
`endif
      case (state_q)
         IDLE: begin
            if (refund) begin
               if (credit_q != '0) begin
                  state_d        = PAYOUT;
                  change_valid_d = 1'b1;
                  change_coin_d  = sel_idx;
               end
               coin_reject_d = coin_any;
            end else if (buy_any) begin
               vend_item_d = buy_idx;
               if (buy_oh && (credit_w >= price_w) && stock_ok) begin
                  vend_ok_d = 1'b1;
                  credit_d  = CREDIT_W'(credit_w - price_w);
`ifdef VM_STOCK_EN
                  stock_d[buy_idx] = stock_q[buy_idx] - STOCK_W'(1);
`endif
               end else begin
                  vend_fail_d = 1'b1;
               end
               coin_reject_d = coin_any;
            end else if (coin_any) begin
               if (coin_oh && (sum_w <= SUM_W'(MAX_CREDIT))) begin
                  coin_accept_d = 1'b1;
                  credit_d      = CREDIT_W'(sum_w);
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
`ifdef VM_STOCK_EN
            if (restock) stock_d = {NUM_ITEMS{STOCK_W'(STOCK_INIT)}};
`endif
         end
         PAYOUT: begin
            coin_reject_d = coin_any;
            vend_fail_d   = buy_any;
            if (buy_any) vend_item_d = buy_idx;
            if (change_valid_q && change_ready) begin
               credit_d = pay_rem;
               if (pay_rem == '0) begin
                  state_d        = IDLE;
                  change_valid_d = 1'b0;
               end else begin
                  change_coin_d = sel_idx;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == PAYOUT);
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         buy_avail_d[i] = (CMP_W'(credit_d) >= CMP_W'(PRICES[i*VAL_BITS +: VAL_BITS]))
`ifdef VM_STOCK_EN
                          && (stock_d[i] != '0)
`endif
                          ;
      end
`ifdef VM_STOCK_EN
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         sold_out_d[i] = (stock_d[i] == '0);
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         coin_accept_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
         vend_ok_q      <= 1'b0;
         vend_fail_q    <= 1'b0;
         vend_item_q    <= '0;
         change_valid_q <= 1'b0;
         change_coin_q  <= '0;
         busy_q         <= 1'b0;
         buy_avail_q    <= '0;
`ifdef VM_STOCK_EN
         stock_q        <= {NUM_ITEMS{STOCK_W'(STOCK_INIT)}};
         sold_out_q     <= {NUM_ITEMS{STOCK_INIT == 0}};
`endif
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         coin_accept_q  <= coin_accept_d;
         coin_reject_q  <= coin_reject_d;
         vend_ok_q      <= vend_ok_d;
         vend_fail_q    <= vend_fail_d;
         vend_item_q    <= vend_item_d;
         change_valid_q <= change_valid_d;
         change_coin_q  <= change_coin_d;
         busy_q         <= busy_d;
         buy_avail_q    <= buy_avail_d;
`ifdef VM_STOCK_EN
         stock_q        <= stock_d;
         sold_out_q     <= sold_out_d;
`endif
      end
   end

   assign credit        = credit_q;
   assign buy_available = buy_avail_q;
   assign coin_accept   = coin_accept_q;
   assign coin_reject   = coin_reject_q;
   assign vend_ok       = vend_ok_q;
   assign vend_fail     = vend_fail_q;
   assign vend_item     = vend_item_q;
   assign change_valid  = change_valid_q;
   assign change_coin   = change_coin_q;
   assign busy          = busy_q;
`ifdef VM_STOCK_EN
   assign sold_out      = sold_out_q;
`endif

endmodule
